ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
Downstream stage of the PS/2 listener. Consumes raw 8-bit scan-code bytes (set 2) and resolves E0/F0 prefix sequences into key make/break events. Events go into a small FIFO with a valid/ready output. The block also keeps a live 8-bit NES button state vector for the controller-emulation path.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2
TIMEOUT_CYCLES, 1000000, CLK cycles a prefix may wait for its next byte before being abandoned

Ports:
CLK  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
code  input  8  scan-code byte from the listener
code_valid  input  1  one-cycle strobe: code is valid this cycle
evt_code  output  8  head event: final (non-prefix) byte
evt_ext  output  1  head event: E0 prefix was present
evt_break  output  1  head event: 1 = release, 0 = press
evt_valid  output  1  FIFO non-empty
evt_ready  input  1  consumer pops the head when evt_valid && evt_ready
buttons  output  8  pressed state: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right
proto_err  output  1  one-cycle pulse on a protocol error or timeout
overflow  output  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high): FSM returns to IDLE; FIFO empties; timeout counter cleared; all outputs are 0.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It advances only on cycles with code_valid=1.
- IDLE transitions:
  - E0 goes to GOT_E0.
  - F0 goes to GOT_F0.
  - Status bytes 00, FF, AA, FA, EE, FE are dropped silently.
  - Any other byte emits a make event (ext=0).
- GOT_E0 transitions:
  - F0 goes to GOT_E0F0.
  - E0 stays in GOT_E0.
  - Any other byte emits a make event (ext=1), then IDLE.
- GOT_F0 transitions:
  - F0 stays in GOT_F0.
  - E0 pulses proto_err and goes to GOT_E0.
  - Any other byte emits a break event (ext=0), then IDLE.
- GOT_E0F0 transitions:
  - E0 or F0 pulses proto_err and restarts from that prefix (GOT_E0 / GOT_F0).
  - Any other byte emits a break event (ext=1), then IDLE.
- Timeout:
  - The counter clears on every code_valid and while in IDLE.
  - In any other state, when the counter reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, pulses proto_err, and emits no event.
- Latency: the event is written into the FIFO at the edge that samples the final byte. With the FIFO empty, evt_valid rises 1 cycle after the code_valid cycle. buttons updates on the same edge.
- FIFO behaviour:
  - Registered, first-in first-out order.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set; overflow clears only on reset.
  - Push and pop on the same cycle while empty: no bypass; the event appears on the next cycle.
- Button map (make sets the bit, break clears it; updated even when the event is dropped by the FIFO):
  - A = 42 ('K'), B = 3B ('J'), Select = 59 (RShift), Start = 5A (Enter). These require ext=0.
  - Up = E0 75, Down = E0 72, Left = E0 6B, Right = E0 74. These require ext=1.
  - A matching code with the wrong ext does not affect buttons.
- Reset mid-sequence: any partial prefix is discarded; no event.

Optional Feature:
TYPEMATIC_FILTER_EN
- Defined: a 9-bit last_make register {ext, code} is kept.
  - A make equal to last_make is not pushed to the FIFO (typematic repeat suppression).
  - A break equal to last_make clears last_make to invalid.
  - buttons is unaffected by the filter.
- Undefined: every make is pushed, including repeats.

Test Plan:
1. Single make: code 1C strobe, evt_ready=0. One cycle later evt_valid=1, evt_code=1C, evt_ext=0, evt_break=0.
2. Extended break: strobes E0, F0, 75 with Up pressed beforehand. Event is {75, ext=1, break=1}; buttons[4] goes 1→0; proto_err stays 0.
3. Overflow: FIFO_DEPTH=4, evt_ready=0, 5 make codes. Exactly 4 queued in order; overflow=1. Pop all: evt_valid drops after the 4th pop.
4. Timeout: F0 strobe, then idle TIMEOUT_CYCLES (use 16 in test). proto_err pulses once; the next byte 1C yields a make, not a break.
5. Errors and reset: F0, E0 sequence gives a proto_err pulse. Assert reset after E0, then send 72. Result: make {72, ext=0}, buttons[5]=0.
6. With TYPEMATIC_FILTER_EN: 42, 42, 42, F0 42, 42. FIFO receives make, break, make (3 events); buttons[0] ends at 1.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// ps2_scancode_decoder : set-2 scan-code prefix resolver, event FIFO and NES
// button state. Optional macro: TYPEMATIC_FILTER_EN (repeat-make suppression).
// Revision: 1.0
// ============================================================================
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] buttons,
  output logic       proto_err,
  output logic       overflow
);

  localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]  c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_ADDR_W:0]   c_FULL     = (c_ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [9:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_rd;
  logic [c_ADDR_W-1:0] r_wr;
  logic [c_ADDR_W:0]   r_count;

  logic       w_emit, w_ext, w_brk, w_err, w_timeout, w_status;
  logic       w_push, w_pop, w_accept, w_btn_hit;
  logic [2:0] w_btn_idx;

  assign w_status = code inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE};
  assign w_timeout = (r_state != IDLE) && !code_valid && (r_cnt == c_TMO_LAST);

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    w_err  = 1'b0;
    if (code_valid) begin
      case (r_state)
        IDLE: begin
          if (code == 8'hE0)      w_next = GOT_E0;
          else if (code == 8'hF0) w_next = GOT_F0;
          else if (!w_status)     w_emit = 1'b1;
        end
        GOT_E0: begin
          if (code == 8'hF0) w_next = GOT_E0F0;
          else if (code != 8'hE0) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_next = IDLE;
          end
        end
        GOT_F0: begin
          if (code == 8'hE0) begin
            w_err  = 1'b1;
            w_next = GOT_E0;
          end else if (code != 8'hF0) begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
            w_next = IDLE;
          end
        end
        default: begin
          if (code == 8'hE0 || code == 8'hF0) begin
            w_err  = 1'b1;
            w_next = (code == 8'hE0) ? GOT_E0 : GOT_F0;
          end else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
            w_next = IDLE;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_err  = 1'b1;
      w_next = IDLE;
    end
  end

  always_comb begin
    w_btn_hit = w_emit;
    w_btn_idx = 3'd0;
    case ({w_ext, code})
      9'h042:  w_btn_idx = 3'd0;
      9'h03B:  w_btn_idx = 3'd1;
      9'h059:  w_btn_idx = 3'd2;
      9'h05A:  w_btn_idx = 3'd3;
      9'h175:  w_btn_idx = 3'd4;
      9'h172:  w_btn_idx = 3'd5;
      9'h16B:  w_btn_idx = 3'd6;
      9'h174:  w_btn_idx = 3'd7;
      default: w_btn_hit = 1'b0;
    endcase
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [8:0] r_last;
  logic       r_last_v;
  logic       w_same;
  assign w_same = r_last_v && (r_last == {w_ext, code});
  assign w_push = w_emit && !(w_same && !w_brk);
`else
  assign w_push = w_emit;
`endif

  assign w_pop    = (r_count != '0) && evt_ready;
  assign w_accept = w_push && ((r_count != c_FULL) || w_pop);

  assign {evt_code, evt_ext, evt_break} = r_mem[r_rd];
  assign evt_valid = (r_count != '0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      buttons   <= '0;
      proto_err <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
`ifdef TYPEMATIC_FILTER_EN
      r_last    <= '0;
      r_last_v  <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_cnt     <= (code_valid || r_state == IDLE) ? '0 : r_cnt + c_CNT_W'(1);
      proto_err <= w_err;
      // Buttons track every resolved event, even ones the FIFO drops.
      if (w_btn_hit) buttons[w_btn_idx] <= !w_brk;
      if (w_push && !w_accept) overflow <= 1'b1;
      if (w_accept) begin
        r_mem[r_wr] <= {code, w_ext, w_brk};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
`ifdef TYPEMATIC_FILTER_EN
      if (w_emit) begin
        if (!w_brk) begin
          r_last   <= {w_ext, code};
          r_last_v <= 1'b1;
        end else if (w_same) begin
          r_last_v <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire
